way_lookup_ctrl: RTL

Fully-associative tag-lookup and miss-allocation controller for one cache set. It sits directly upstream of the LRU eviction policy and drives that block's one-hot `hitWay` / `allocateWay` access pulses. On a miss with the set full, it requests and consumes the policy's `evictionTarget`. It holds the tag/valid array and returns one response per accepted request.

---
 rtl/way_lookup_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/way_lookup_ctrl.sv
// way_lookup_ctrl
// Fully-associative tag lookup and miss allocation for one cache set.
// Holds the tag/valid array, returns one response per accepted request and
// drives one-hot hit/allocate pulses to the downstream LRU eviction policy.
// When the set is full on a miss, a victim is requested from that policy.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   reqValid/reqReady/reqTag lookup request handshake and tag
//   invalidateAll            flush all valid bits (honored in IDLE only)
//   rspValid/rspHit/rspWay   one-cycle response strobe, hit flag, way index
//   rspEvicted/rspEvictTag   miss displaced a valid line, and its tag
//   hitWay/allocateWay       one-hot access pulses to the eviction policy
//   evictReq                 victim request (level, EVICT_WAIT only)
//   evictionTarget/Ready     one-hot victim from the policy and its valid
module way_lookup_ctrl #(
   parameter int NUM_WAYS  = 8,
   parameter int TAG_WIDTH = 20,
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic [TAG_WIDTH-1:0] reqTag,
   input  logic                 invalidateAll,
   output logic                 rspValid,
   output logic                 rspHit,
   output logic [WAY_W-1:0]     rspWay,
   output logic                 rspEvicted,
   output logic [TAG_WIDTH-1:0] rspEvictTag,
   output logic [NUM_WAYS-1:0]  hitWay,
   output logic [NUM_WAYS-1:0]  allocateWay,
   output logic                 evictReq,
   input  logic [NUM_WAYS-1:0]  evictionTarget,
   input  logic                 evictionReady
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LOOKUP     = 2'd1,
      S_EVICT_WAIT = 2'd2,
      S_RESP       = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [TAG_WIDTH-1:0] tag_reg, tag_next;
   logic [WAY_W-1:0]     way_reg, way_next;
   logic                 hit_reg, hit_next;
   logic                 evicted_reg, evicted_next;
   logic [TAG_WIDTH-1:0] evict_tag_reg, evict_tag_next;
   logic [NUM_WAYS-1:0]  valid_reg, valid_next;
   logic [TAG_WIDTH-1:0] tags_reg [NUM_WAYS];

   logic [NUM_WAYS-1:0]  match;
   logic [WAY_W-1:0]     victim_idx;

   // Lowest set bit wins; also resolves duplicate tags should they ever occur.
   function automatic logic [WAY_W-1:0] lowest_idx(input logic [NUM_WAYS-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = WAY_W'(i);
      end
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WAYS; gi++) begin : g_match
         assign match[gi] = valid_reg[gi] && (tags_reg[gi] == tag_reg);
      end
   endgenerate

   assign victim_idx = lowest_idx(evictionTarget);

   always_comb begin
      state_next     = state_reg;
      tag_next       = tag_reg;
      way_next       = way_reg;
      hit_next       = hit_reg;
      evicted_next   = evicted_reg;
      evict_tag_next = evict_tag_reg;
      valid_next     = valid_reg;
      case (state_reg)
         S_IDLE: begin
            if (invalidateAll) begin
               valid_next = '0;
            end else if (reqValid) begin
               tag_next   = reqTag;
               state_next = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (|match) begin
               hit_next       = 1'b1;
               way_next       = lowest_idx(match);
               evicted_next   = 1'b0;
               evict_tag_next = '0;
               state_next     = S_RESP;
            end else if (!(&valid_reg)) begin
               hit_next       = 1'b0;
               way_next       = lowest_idx(~valid_reg);
               evicted_next   = 1'b0;
               evict_tag_next = '0;
               state_next     = S_RESP;
            end else begin
               state_next = S_EVICT_WAIT;
            end
         end
         S_EVICT_WAIT: begin
            // A ready with an empty target is not a usable victim; keep waiting.
            if (evictionReady && (|evictionTarget)) begin
               hit_next       = 1'b0;
               way_next       = victim_idx;
               evicted_next   = 1'b1;
               evict_tag_next = tags_reg[victim_idx];
               state_next     = S_RESP;
            end
         end
         S_RESP: begin
            if (!hit_reg) valid_next[way_reg] = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         tag_reg       <= '0;
         way_reg       <= '0;
         hit_reg       <= 1'b0;
         evicted_reg   <= 1'b0;
         evict_tag_reg <= '0;
         valid_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         tag_reg       <= tag_next;
         way_reg       <= way_next;
         hit_reg       <= hit_next;
         evicted_reg   <= evicted_next;
         evict_tag_reg <= evict_tag_next;
         valid_reg     <= valid_next;
      end
   end

   // Tag storage has no reset: contents only matter once the valid bit is set.
   always_ff @(posedge clk) begin
      if (state_reg == S_RESP && !hit_reg) tags_reg[way_reg] <= tag_reg;
   end

   // Outputs decode from state so reset forces them low without waiting for a clock.
   assign reqReady    = (state_reg == S_IDLE) && !invalidateAll && !reset;
   assign rspValid    = (state_reg == S_RESP);
   assign rspHit      = rspValid && hit_reg;
   assign rspWay      = rspValid ? way_reg : '0;
   assign rspEvicted  = rspValid && evicted_reg;
   assign rspEvictTag = rspEvicted ? evict_tag_reg : '0;
   assign hitWay      = (rspValid && hit_reg)  ? (NUM_WAYS'(1) << way_reg) : '0;
   assign allocateWay = (rspValid && !hit_reg) ? (NUM_WAYS'(1) << way_reg) : '0;
   assign evictReq    = (state_reg == S_EVICT_WAIT);

endmodule
